// File: rtl/conversor_binario_bcd.sv
// rtl/conversor_binario_bcd.sv - sequential signed 16-bit binary to sign+5-digit BCD converter
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous reset, active low
//   producto   in  16   two's-complement value, sampled on an accepted start
//   inicio     in   1   start request, accepted only in IDLE
//   codigo_BCD out  21   {sign, 5 BCD digits}, held until the next completed conversion
//   ocupado    out  1   conversion in progress
//   listo      out  1   one-cycle pulse when a new codigo_BCD is first valid
module conversor_binario_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] producto,
  input  logic        inicio,
  output logic [20:0] codigo_BCD,
  output logic        ocupado,
  output logic        listo
);

  typedef enum logic {IDLE, CONVERTIR} estado_t;

  estado_t     estado_q, estado_d;
  logic        signo_q, signo_d;
  logic [15:0] magnitud_q, magnitud_d;
  logic [19:0] scratch_q, scratch_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [20:0] codigo_q, codigo_d;
  logic        ocupado_q, ocupado_d;
  logic        listo_q, listo_d;

  // Add-3 correction of every digit >= 5 before the shift. The
  // ten-thousands digit's top bit is shifted out, so only its low three
  // bits are kept (adding 3 mod 8 gives the same low bits).
  logic [18:0] scratch_adj;

  always_comb begin
    scratch_adj = scratch_q[18:0];
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    if (scratch_q[19:16] >= 4'd5) begin
      scratch_adj[18:16] = scratch_q[18:16] + 3'd3;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    signo_d    = signo_q;
    magnitud_d = magnitud_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    codigo_d   = codigo_q;
    ocupado_d  = ocupado_q;
    listo_d    = 1'b0;

    case (estado_q)
      IDLE: begin
        if (inicio) begin
          signo_d = producto[15];
          // -32768 negates to 0x8000, which is the correct unsigned magnitude
          magnitud_d = producto[15] ? (~producto + 16'd1) : producto;
          scratch_d  = 20'd0;
          cnt_d      = 4'd0;
          ocupado_d  = 1'b1;
          estado_d   = CONVERTIR;
        end
      end

      CONVERTIR: begin
        scratch_d  = {scratch_adj, magnitud_q[15]};
        magnitud_d = {magnitud_q[14:0], 1'b0};
        cnt_d      = cnt_q + 4'd1;
        // Sixteenth bit processed: publish the finished word this edge
        if (cnt_q == 4'd15) begin
          codigo_d  = {signo_q, scratch_d};
          listo_d   = 1'b1;
          ocupado_d = 1'b0;
          estado_d  = IDLE;
        end
      end

      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= IDLE;
      signo_q    <= 1'b0;
      magnitud_q <= 16'd0;
      scratch_q  <= 20'd0;
      cnt_q      <= 4'd0;
      codigo_q   <= 21'd0;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      signo_q    <= signo_d;
      magnitud_q <= magnitud_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      codigo_q   <= codigo_d;
      ocupado_q  <= ocupado_d;
      listo_q    <= listo_d;
    end
  end

  assign codigo_BCD = codigo_q;
  assign ocupado    = ocupado_q;
  assign listo      = listo_q;

endmodule

// File: tb/tb_conversor_binario_bcd.sv
// tb/tb_conversor_binario_bcd.sv - self-checking bench for conversor_binario_bcd
module tb_conversor_binario_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] producto = 16'd0;
  logic        inicio = 1'b0;
  logic [20:0] codigo_BCD;
  logic        ocupado;
  logic        listo;

  int vectors = 0;
  int miscompares = 0;
  logic [20:0] exp_last = 21'd0;

  conversor_binario_bcd dut (
    .clk        (clk),
    .reset      (reset),
    .producto   (producto),
    .inicio     (inicio),
    .codigo_BCD (codigo_BCD),
    .ocupado    (ocupado),
    .listo      (listo)
  );

  always #5 clk = ~clk;

  // Reference: sign flag plus decimal digits of |value|
  function automatic logic [20:0] ref_bcd(input logic [15:0] p);
    int v;
    int m;
    logic neg;
    v   = $signed(p);
    neg = (v < 0);
    m   = neg ? -v : v;
    return {neg, 4'(m / 10000), 4'((m / 1000) % 10), 4'((m / 100) % 10),
            4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic check21(input string tag, input logic [20:0] obs, input logic [20:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // One conversion with per-cycle protocol checks. poke_busy pulses
  // inicio with 9999 between E7 and E8 to verify it is ignored.
  task automatic run_conv(input string tag, input logic [15:0] p, input logic [20:0] expv,
                          input logic poke_busy, input logic check_digits);
    logic busy_ok;
    logic dig_ok;
    @(negedge clk);
    producto = p;
    inicio   = 1'b1;
    @(negedge clk);
    inicio   = 1'b0;
    busy_ok  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (!(ocupado === 1'b1 && listo === 1'b0 && codigo_BCD === exp_last)) busy_ok = 1'b0;
      producto = 16'($urandom);
      if (poke_busy && k == 7) begin
        producto = 16'd9999;
        inicio   = 1'b1;
      end else begin
        inicio = 1'b0;
      end
      @(negedge clk);
    end
    inicio = 1'b0;
    check1({tag, "_busy_window"}, busy_ok, 1'b1);
    check21({tag, "_result"}, codigo_BCD, expv);
    check1({tag, "_listo_E16"}, listo, 1'b1);
    check1({tag, "_ocupado_E16"}, ocupado, 1'b0);
    if (check_digits) begin
      dig_ok = 1'b1;
      for (int d = 0; d < 5; d++) if (codigo_BCD[4*d +: 4] > 4'd9) dig_ok = 1'b0;
      check1({tag, "_digits_le9"}, dig_ok, 1'b1);
    end
    @(negedge clk);
    check1({tag, "_listo_E17"}, listo, 1'b0);
    exp_last = expv;
  endtask

  initial begin
    logic quiet;
    logic [15:0] rp;
    int  wait_cnt;

    // Reset values
    repeat (3) @(negedge clk);
    check21("in_reset_codigo", codigo_BCD, 21'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check21("reset_codigo", codigo_BCD, 21'd0);
    check1("reset_ocupado", ocupado, 1'b0);
    check1("reset_listo", listo, 1'b0);

    // Directed values
    run_conv("p1234", 16'h04D2, 21'h001234, 1'b0, 1'b0);
    run_conv("zero", 16'h0000, 21'h000000, 1'b0, 1'b0);
    run_conv("max_pos", 16'h7FFF, 21'h032767, 1'b0, 1'b0);
    run_conv("minus1", 16'hFFFF, 21'h100001, 1'b0, 1'b0);
    run_conv("min_neg", 16'h8000, 21'h132768, 1'b0, 1'b0);
    run_conv("m1234", 16'hFB2E, 21'h101234, 1'b0, 1'b0);

    // Start while busy: inicio at E8 ignored, no second listo
    run_conv("busy5", 16'd5, 21'h000005, 1'b1, 1'b0);
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (listo !== 1'b0 || ocupado !== 1'b0 || codigo_BCD !== 21'h000005) quiet = 1'b0;
    end
    check1("busy5_no_second_run", quiet, 1'b1);

    // Reset mid-conversion
    run_conv("pre_reset", 16'h04D2, 21'h001234, 1'b0, 1'b0);
    @(negedge clk);
    producto = 16'hFFB3;
    inicio   = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check21("midreset_codigo", codigo_BCD, 21'd0);
    check1("midreset_ocupado", ocupado, 1'b0);
    check1("midreset_listo", listo, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (listo !== 1'b0 || ocupado !== 1'b0 || codigo_BCD !== 21'd0) quiet = 1'b0;
    end
    check1("midreset_stays_idle", quiet, 1'b1);
    exp_last = 21'd0;
    run_conv("m77", 16'hFFB3, 21'h100077, 1'b0, 1'b0);

    // Back-to-back: inicio held high reconverts every 17 cycles
    @(negedge clk);
    producto = 16'd42;
    inicio   = 1'b1;
    wait_cnt = 0;
    while (listo !== 1'b1 && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    check1("b2b_first_listo", listo, 1'b1);
    check21("b2b_first_result", codigo_BCD, 21'h000042);
    producto = 16'hFFF6;
    wait_cnt = 0;
    do begin
      @(negedge clk);
      wait_cnt++;
    end while (listo !== 1'b1 && wait_cnt < 40);
    inicio = 1'b0;
    vectors++;
    assert (wait_cnt == 17) else begin
      miscompares++;
      $error("FAIL b2b_period observed=%0d expected=17", wait_cnt);
    end
    check21("b2b_second_result", codigo_BCD, 21'h100010);
    exp_last = 21'h100010;
    @(negedge clk);
    repeat (2) @(negedge clk);

    // Randomized sweep
    for (int n = 0; n < 500; n++) begin
      rp = 16'($urandom);
      run_conv("rand", rp, ref_bcd(rp), 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
